fib_datapath: RTL

- Datapath paired with the Fibonacci control unit. It holds the requested index, the step counter, the Fibonacci pair registers, the adder and the output register.
- It consumes the controller's strobes (counter_reset, counter_enb, mux_sel, load_output) and the top-level load_input.
- It returns counter and count_to to the controller for its termination compare.
- Result and overflow flag are presented to the top level.

---
 rtl/fib_pkg.sv | 26 ++
 rtl/fib_datapath_if.sv | 26 ++
 rtl/fib_step_counter.sv | 20 ++
 rtl/fib_datapath.sv | 77 +++++++
 4 files changed

// File: rtl/fib_pkg.sv
// Shared constants and the pair-operation decode for the Fibonacci datapath.
package fib_pkg;

  localparam int CNT_W     = 5;
  localparam int SEED_PREV = 0;
  localparam int SEED_CURR = 1;
  localparam int MAX_N_W16 = 24;

  typedef enum logic [1:0] {
    PAIR_HOLD,
    PAIR_SEED,
    PAIR_ADVANCE
  } pair_op_e;

  // Clear beats seed/advance; a seed and a clear have identical effect on the pair.
  function automatic pair_op_e decode_pair_op(input logic counter_reset,
                                              input logic counter_enb,
                                              input logic mux_sel);
    // NOTE: default first so every path assigns op and no latch can be inferred.
    pair_op_e op = PAIR_HOLD;
    if (!counter_reset)          op = PAIR_SEED;
    else if (counter_enb)        op = mux_sel ? PAIR_SEED : PAIR_ADVANCE;
    return op;
  endfunction

endpackage

// File: rtl/fib_datapath_if.sv
// Strobe/result bundle between the Fibonacci controller (master) and datapath (slave).
interface fib_datapath_if #(parameter int W = 16) ();
  import fib_pkg::*;

  logic             load_input;
  logic [CNT_W-1:0] n_in;
  logic             counter_reset;
  logic             counter_enb;
  logic             mux_sel;
  logic             load_output;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] count_to;
  logic [W-1:0]     fib_out;
  logic             overflow;

  modport master (
    output load_input, n_in, counter_reset, counter_enb, mux_sel, load_output,
    input  counter, count_to, fib_out, overflow
  );

  modport slave (
    input  load_input, n_in, counter_reset, counter_enb, mux_sel, load_output,
    output counter, count_to, fib_out, overflow
  );

endinterface

// File: rtl/fib_step_counter.sv
// Step counter: active-low synchronous clear, seed clear, enable; wraps modulo 2^CNT_W.
module fib_step_counter
  import fib_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_n,
  input  logic             seed,
  input  logic             enb,
  output logic [CNT_W-1:0] count
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                count <= '0;
    else if (!clear_n || seed) count <= '0;
    else if (enb)              count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/fib_datapath.sv
// Fibonacci datapath: requested index, step counter, (prev,curr) pair with adder, result register.
module fib_datapath
  import fib_pkg::*;
#(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           reset,
  fib_datapath_if.slave  bus
);

  pair_op_e     pair_op;
  logic [W-1:0] prev;
  logic [W-1:0] curr;
  logic [W:0]   sum;
  logic         curr_ovf;
  logic         ovf_acc;
  logic [CNT_W-1:0] count_to_q;

  assign pair_op = decode_pair_op(bus.counter_reset, bus.counter_enb, bus.mux_sel);
  assign sum     = {1'b0, prev} + {1'b0, curr};

  fib_step_counter u_counter (
    .clk     (clk),
    .reset   (reset),
    .clear_n (bus.counter_reset),
    .seed    (bus.counter_enb & bus.mux_sel),
    .enb     (bus.counter_enb),
    .count   (bus.counter)
  );

  // NOTE: every register here is reset; nothing is memory-like, so no flop is left uninitialised.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              count_to_q <= '0;
    else if (bus.load_input) count_to_q <= bus.n_in;
  end

  assign bus.count_to = count_to_q;

  // curr_ovf marks that curr has exceeded W bits; ovf_acc follows it into prev,
  // so the flag describes the value that load_output actually publishes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev     <= W'(SEED_PREV);
      curr     <= W'(SEED_CURR);
      curr_ovf <= 1'b0;
      ovf_acc  <= 1'b0;
    end else begin
      case (pair_op)
        PAIR_SEED: begin
          prev     <= W'(SEED_PREV);
          curr     <= W'(SEED_CURR);
          curr_ovf <= 1'b0;
          ovf_acc  <= 1'b0;
        end
        PAIR_ADVANCE: begin
          prev     <= curr;
          curr     <= sum[W-1:0];
          curr_ovf <= curr_ovf | sum[W];
          ovf_acc  <= ovf_acc | curr_ovf;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.fib_out  <= '0;
      bus.overflow <= 1'b0;
    end else if (bus.load_output) begin
      bus.fib_out  <= prev;
      bus.overflow <= ovf_acc;
    end
  end

endmodule
